jk_drive_sequencer: RTL and testbench
=====================================

// Module: jk_drive_sequencer
// PURPOSE
//  Upstream driver for the JK flip-flop stage: accepts queued commands (hold/reset/set/toggle + duration)
//  over a valid/ready port, drives the flop's j/k/rst inputs cycle by cycle, and checks the flop's q
//  against an internal JK model after each command. Used as stimulus/self-check front end for JK-based logic.
// PARAMETERS
//  DEPTH  4  command FIFO entries, power of 2, >=2
//  LEN_W  4  width of per-command duration field
//  CNT_W  8  width of saturating mismatch counter
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  cmd_valid  in   1      command offered
//  cmd_ready  out  1      FIFO can accept (= !full)
//  cmd_op     in   2      {j,k} code: 00 hold, 01 reset, 10 set, 11 toggle
//  cmd_len    in   LEN_W  drive duration = cmd_len+1 cycles
//  q_in       in   1      q from the driven JK flop
//  j, k       out  1      registered drive to the flop
//  ff_rst     out  1      registered synchronous reset to the flop
//  busy       out  1      state != IDLE or FIFO non-empty
//  err        out  1      sticky mismatch flag
//  err_cnt    out  CNT_W  mismatch count, saturating
//  clr_err    in   1      clears err and err_cnt
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high (clk, rst). Reset values: j=k=0, ff_rst=1,
//    err=0, err_cnt=0, FIFO empty, q_exp=0, state=INIT. cmd_ready=0 while in INIT.
//  - Push: cmd_valid && cmd_ready at edge. Push when full impossible (ready low); push+pop same edge
//    when not full both take effect, count unchanged. Pop only when non-empty. Pointers wrap mod DEPTH.
//  - FSM INIT -> IDLE -> DRIVE -> CHECK -> {DRIVE | IDLE}:
//    INIT: one cycle after rst release, ff_rst=1 (gives the flop its sync reset edge); -> IDLE, ff_rst<=0.
//    IDLE: j=k=0; if FIFO non-empty: pop, {j,k}<=op, cnt<=len, -> DRIVE.
//    DRIVE: each edge update q_exp per JK table using current {j,k}; if cnt==0: {j,k}<=00, -> CHECK,
//      else cnt<=cnt-1. So op is presented for exactly len+1 edges.
//    CHECK: j=k=0; q_in compared to q_exp (flop output now reflects last drive edge). Mismatch: err<=1,
//      err_cnt<=err_cnt+1 unless all-ones. Then pop next command straight to DRIVE if non-empty, else IDLE.
//  - Latency: command pushed into empty FIFO in IDLE at edge t -> popped edge t+1 -> j/k valid after t+1.
//    Back-to-back commands: exactly one CHECK cycle (j=k=0) between drives.
//  - clr_err and mismatch same cycle: mismatch wins (err=1, err_cnt=1 from cleared base).
//  - rst mid-operation: immediate return to reset values; queued commands discarded; INIT reruns.
//  - cmd_op/cmd_len not sampled unless push occurs; outputs j,k,ff_rst glitch-free (registered).
// STRUCTURE
//  - Package jk_pkg: op localparams OP_HOLD=2'b00, OP_RESET=2'b01, OP_SET=2'b10, OP_TOGGLE=2'b11;
//    FSM state encoding (INIT, IDLE, DRIVE, CHECK); function jk_next(q,op) used by RTL and bench model.
//  - One sub-module: jk_cmd_fifo (DEPTH x (2+LEN_W), count-based full/empty, async reset).
//  - Top holds FSM, duration counter, q_exp model, error logic.
// TESTING
//  1. Reset release: ff_rst=1 for exactly 1 cycle, then 0; cmd_ready 0->1; j=k=0; busy=0; err=0.
//  2. Push SET len=0 then TOGGLE len=2 back-to-back: j,k=10 one cycle, 00 one cycle, 11 three cycles;
//     q final = 0 (1 toggled 3x); no err; busy drops one cycle after final CHECK.
//  3. Fill 4 commands with FSM stalled in DRIVE (len=15): cmd_ready=0 on 4th; 5th held;
//     accepted after first pop; execution order = push order.
//  4. Force q_in stuck at 0, push SET len=0: err=1, err_cnt=1 in cycle after CHECK; clr_err same
//     cycle as second mismatch -> err=1, err_cnt=1.
//  5. 300 forced mismatches with CNT_W=8: err_cnt saturates at 255.
//  6. Assert rst during DRIVE of TOGGLE len=7: j=k=0 and ff_rst=1 immediately (async), FIFO empty,
//     pending commands never executed; INIT rerun after release.

Source files
------------

// File: rtl/jk_drive_sequencer_pkg.sv
// Shared op codes, FSM encoding and the JK next-state rule for the drive sequencer.
package jk_pkg;

    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_RESET  = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_DRIVE = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    // JK characteristic table: op is the {j,k} pair applied at one clock edge.
    function automatic logic jk_next(input logic q, input logic [1:0] op);
        logic nq;
        case (op)
            OP_HOLD:  nq = q;
            OP_RESET: nq = 1'b0;
            OP_SET:   nq = 1'b1;
            default:  nq = ~q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/jk_drive_sequencer_if.sv
// Command port of the JK drive sequencer.
// Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready are both high;
// cmd_op/cmd_len are only meaningful in that cycle, and cmd_ready never depends on cmd_valid.
interface jk_drive_sequencer_if #(
    parameter int LEN_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [LEN_W-1:0] cmd_len;

    modport master (output cmd_valid, output cmd_op, output cmd_len, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_len, output cmd_ready);
endinterface

// File: rtl/jk_drive_sequencer_fifo.sv
// Command FIFO: DEPTH entries, count-based full/empty, head entry visible on dout_o.
module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; simultaneous push/pop keeps count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/jk_drive_sequencer.sv
// JK drive sequencer: pops queued commands, drives j/k/ff_rst of an external JK flop,
// tracks the expected flop output and counts mismatches after each command.
module jk_drive_sequencer
    import jk_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    jk_drive_sequencer_if.slave  cmd,
    input  logic                 q_in,
    output logic                 j,
    output logic                 k,
    output logic                 ff_rst,
    output logic                 busy,
    output logic                 err,
    output logic [CNT_W-1:0]     err_cnt,
    input  logic                 clr_err,
    output state_t               dbg_state
);
    localparam int FW = 2 + LEN_W;

    state_t           state_q, state_d;
    logic             j_q, j_d, k_q, k_d;
    logic             ff_rst_q, ff_rst_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             q_exp_q, q_exp_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             push, pop, mismatch;
    logic [FW-1:0]    head;
    logic             fifo_full, fifo_empty;
    logic [1:0]       head_op;
    logic [LEN_W-1:0] head_len;

    // Commands are refused while the flop is still receiving its reset pulse.
    assign cmd.cmd_ready = !fifo_full && (state_q != ST_INIT);
    assign push          = cmd.cmd_valid && cmd.cmd_ready;
    assign head_op       = head[FW-1:LEN_W];
    assign head_len      = head[LEN_W-1:0];

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   ({cmd.cmd_op, cmd.cmd_len}),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_INIT;
        else     state_q <= state_d;
    end

    // Next-state logic: CHECK chains straight into the next command when one is queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  state_d = ST_IDLE;
            ST_IDLE:  if (!fifo_empty) state_d = ST_DRIVE;
            ST_DRIVE: if (cnt_q == '0) state_d = ST_CHECK;
            ST_CHECK: state_d = fifo_empty ? ST_IDLE : ST_DRIVE;
            default:  state_d = ST_INIT;
        endcase
    end

    // Output/datapath logic: next drive values, duration counter, expected q and pop strobe.
    always_comb begin
        pop      = 1'b0;
        mismatch = 1'b0;
        j_d      = j_q;
        k_d      = k_q;
        ff_rst_d = 1'b0;
        cnt_d    = cnt_q;
        q_exp_d  = q_exp_q;
        case (state_q)
            ST_INIT: begin
                j_d = 1'b0;
                k_d = 1'b0;
            end
            ST_IDLE, ST_CHECK: begin
                // The flop has held since the last drive edge, so q_in is settled here.
                mismatch = (state_q == ST_CHECK) && (q_in != q_exp_q);
                j_d = 1'b0;
                k_d = 1'b0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    {j_d, k_d} = head_op;
                    cnt_d      = head_len;
                end
            end
            ST_DRIVE: begin
                // The flop samples the current j/k at this same edge.
                q_exp_d = jk_next(q_exp_q, {j_q, k_q});
                if (cnt_q == '0) {j_d, k_d} = 2'b00;
                else             cnt_d = cnt_q - LEN_W'(1);
            end
            default: begin
                j_d = 1'b0;
                k_d = 1'b0;
            end
        endcase
    end

    // Error flag/counter: a mismatch outranks a clear, counting from a cleared base.
    always_comb begin
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (mismatch) begin
            err_d = 1'b1;
            if (clr_err)                err_cnt_d = CNT_W'(1);
            else if (err_cnt_q != '1)   err_cnt_d = err_cnt_q + CNT_W'(1);
        end else if (clr_err) begin
            err_d     = 1'b0;
            err_cnt_d = '0;
        end
    end

    // Registered outputs and datapath; reset asserts the flop reset and clears the model.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            j_q       <= 1'b0;
            k_q       <= 1'b0;
            ff_rst_q  <= 1'b1;
            cnt_q     <= '0;
            q_exp_q   <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            j_q       <= j_d;
            k_q       <= k_d;
            ff_rst_q  <= ff_rst_d;
            cnt_q     <= cnt_d;
            q_exp_q   <= q_exp_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign j         = j_q;
    assign k         = k_q;
    assign ff_rst    = ff_rst_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_jk_drive_sequencer.sv
module tb_jk_drive_sequencer;
  import jk_pkg::*;

  localparam int LEN_W   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             q_in;
  logic             j, k, ff_rst, busy, err, clr_err;
  logic [CNT_W-1:0] err_cnt;
  state_t           dbg_state;

  jk_drive_sequencer_if #(.LEN_W(LEN_W)) cmd_if ();

  jk_drive_sequencer #(.DEPTH(4), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd_if),
    .q_in      (q_in),
    .j         (j),
    .k         (k),
    .ff_rst    (ff_rst),
    .busy      (busy),
    .err       (err),
    .err_cnt   (err_cnt),
    .clr_err   (clr_err),
    .dbg_state (dbg_state)
  );

  // External JK flop driven by the DUT, with an optional stuck-at override on its output.
  logic flop_q = 1'b0;
  logic force_en = 1'b0;
  logic force_val = 1'b0;
  always @(posedge clk) begin
    if (ff_rst) flop_q <= 1'b0;
    else begin
      case ({j, k})
        2'b01:   flop_q <= 1'b0;
        2'b10:   flop_q <= 1'b1;
        2'b11:   flop_q <= ~flop_q;
        default: flop_q <= flop_q;
      endcase
    end
  end
  assign q_in = force_en ? force_val : flop_q;

  // ---------------- scoreboard state ----------------
  // entry = {op[1:0], len[3:0], q_after}
  logic [6:0] exp_q[$];
  logic       model_q = 1'b0;
  int         n_pass = 0;
  int         n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  // Command-level result of running one command on a flop that starts at q.
  function automatic logic cmd_result(input logic q, input logic [1:0] op, input logic [3:0] len);
    int edges;
    edges = int'(len) + 1;
    case (op)
      OP_HOLD:  return q;
      OP_RESET: return 1'b0;
      OP_SET:   return 1'b1;
      default:  return (edges % 2 == 1) ? ~q : q;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Call about #1 after a rising edge; returns #1 after the edge that accepted the command.
  task automatic push_cmd(input logic [1:0] op, input logic [3:0] len);
    bit done;
    done = 0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_len   = len;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (cmd_if.cmd_ready) begin
        model_q = cmd_result(model_q, op, len);
        exp_q.push_back({op, len, model_q});
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    cmd_if.cmd_valid = 1'b0;
    check("push_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) ok = 1;
    end
    check("wait_idle_timeout", 32'(ok), 32'd1);
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
  endtask

  task automatic clr_during_check();
    bit hit;
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk);
      #1;
      if (dbg_state == ST_CHECK) begin
        clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        hit = 1;
      end
    end
    check("clr_check_timeout", 32'(hit), 32'd1);
  endtask

  task automatic random_cmds(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      push_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
    end
  endtask

  // ---------------- monitor ----------------
  int         run_len = 0;
  logic [1:0] run_jk = 2'b00;
  bit         run_bad = 0;
  logic       m_err = 1'b0;
  int         m_cnt = 0;
  logic [6:0] e;
  bit         mism;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        run_len = 0;
        run_bad = 0;
        m_err   = 1'b0;
        m_cnt   = 0;
      end else begin
        mism = 0;
        check("err", 32'(err), 32'(m_err));
        check("err_cnt", 32'(err_cnt), 32'(m_cnt));
        case (dbg_state)
          ST_DRIVE: begin
            if (run_len == 0) run_jk = {j, k};
            else if ({j, k} != run_jk) run_bad = 1;
            run_len++;
          end
          ST_CHECK: begin
            check("check_jk", 32'({j, k}), 32'd0);
            if (exp_q.size() == 0) begin
              check("unexpected_cmd", 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              check("drive_op", 32'(run_jk), 32'(e[6:5]));
              check("drive_len", 32'(run_len), 32'(e[4:1]) + 32'd1);
              check("drive_steady", 32'(run_bad), 32'd0);
              if (!force_en) check("q_after_cmd", 32'(q_in), 32'(e[0]));
              mism = (q_in != e[0]);
            end
            run_len = 0;
            run_bad = 0;
          end
          default: check("idle_jk", 32'({j, k}), 32'd0);
        endcase
        // Error state expected after the coming edge.
        if (mism) begin
          m_err = 1'b1;
          m_cnt = clr_err ? 1 : ((m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1);
        end else if (clr_err) begin
          m_err = 1'b0;
          m_cnt = 0;
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  logic [1:0] seq [6];
  int         nz;

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_len   = '0;
    clr_err          = 1'b0;
    seq = '{2'b10, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00};

    // 1. reset values and INIT pulse
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_j", 32'(j), 32'd0);
    check("rst_k", 32'(k), 32'd0);
    check("rst_ff_rst", 32'(ff_rst), 32'd1);
    check("rst_ready", 32'(cmd_if.cmd_ready), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("init_ff_rst", 32'(ff_rst), 32'd1);
    check("init_ready", 32'(cmd_if.cmd_ready), 32'd0);
    @(negedge clk);
    check("idle_ff_rst", 32'(ff_rst), 32'd0);
    check("idle_ready", 32'(cmd_if.cmd_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_j_k", 32'({j, k}), 32'd0);

    // 2. SET len0 then TOGGLE len2 back-to-back
    @(posedge clk);
    #1;
    push_cmd(OP_SET, 4'd0);
    push_cmd(OP_TOGGLE, 4'd2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("b2b_jk_seq", 32'({j, k}), 32'(seq[i]));
    end
    @(negedge clk);
    check("b2b_busy_drop", 32'(busy), 32'd0);
    check("b2b_q_final", 32'(q_in), 32'd0);

    // 3. fill the FIFO while a long command drives
    @(posedge clk);
    #1;
    push_cmd(OP_TOGGLE, 4'd15);
    repeat (2) @(posedge clk);
    #1;
    check("fill_in_drive", 32'(dbg_state), 32'(ST_DRIVE));
    push_cmd(OP_SET, 4'd1);
    push_cmd(OP_RESET, 4'd0);
    push_cmd(OP_HOLD, 4'd2);
    check("fill_ready_3", 32'(cmd_if.cmd_ready), 32'd1);
    push_cmd(OP_TOGGLE, 4'd1);
    check("fill_ready_4", 32'(cmd_if.cmd_ready), 32'd0);
    push_cmd(OP_SET, 4'd0);
    wait_idle();

    // random traffic, healthy flop
    @(posedge clk);
    #1;
    random_cmds(40);
    wait_idle();

    // 4. stuck-at-0 flop: mismatch, then clear colliding with a mismatch
    force_val = 1'b0;
    force_en  = 1'b1;
    @(posedge clk);
    #1;
    push_cmd(OP_SET, 4'd0);
    wait_idle();
    check("stuck_err", 32'(err), 32'd1);
    check("stuck_err_cnt", 32'(err_cnt), 32'd1);
    @(posedge clk);
    #1;
    fork
      push_cmd(OP_SET, 4'd0);
      clr_during_check();
    join
    wait_idle();
    check("clr_vs_mism_err", 32'(err), 32'd1);
    check("clr_vs_mism_cnt", 32'(err_cnt), 32'd1);
    pulse_clr();
    @(negedge clk);
    check("clr_err", 32'(err), 32'd0);

    // 5. saturation
    @(posedge clk);
    #1;
    for (int i = 0; i < 300; i++) push_cmd(OP_SET, 4'd0);
    wait_idle();
    check("sat_err_cnt", 32'(err_cnt), 32'(CNT_MAX));
    pulse_clr();

    // random traffic, stuck-at-1 flop
    force_val = 1'b1;
    @(posedge clk);
    #1;
    random_cmds(40);
    wait_idle();
    force_en = 1'b0;

    // 6. reset during a drive discards queued commands
    @(posedge clk);
    #1;
    push_cmd(OP_TOGGLE, 4'd7);
    push_cmd(OP_SET, 4'd3);
    push_cmd(OP_RESET, 4'd2);
    check("rst_mid_in_drive", 32'(dbg_state), 32'(ST_DRIVE));
    @(posedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    model_q = 1'b0;
    #1;
    check("rst_mid_j_k", 32'({j, k}), 32'd0);
    check("rst_mid_ff_rst", 32'(ff_rst), 32'd1);
    check("rst_mid_ready", 32'(cmd_if.cmd_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rerun_init_ff_rst", 32'(ff_rst), 32'd1);
    @(negedge clk);
    check("rerun_idle_ff_rst", 32'(ff_rst), 32'd0);
    nz = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ({j, k} != 2'b00 || dbg_state != ST_IDLE) nz++;
    end
    check("discarded_cmds", 32'(nz), 32'd0);
    check("rerun_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
